// File: rtl/lwb_pkg.sv
// Shared helpers for the line window buffer: counter-width functions used to
// size the x/y coordinate ports and the line-memory address.
package lwb_pkg;

  // Width of a counter spanning 0..n-1, never narrower than one bit.
  function automatic int X_W(input int img_w);
    return (img_w > 1) ? $clog2(img_w) : 1;
  endfunction

  function automatic int Y_W(input int img_h);
    return (img_h > 1) ? $clog2(img_h) : 1;
  endfunction

endpackage

// File: rtl/lwb_line_mem.sv
// One image line of storage: synchronous write, combinational read that
// returns the old word when reading and writing the same address.
module lwb_line_mem
  import lwb_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8,
  parameter int AW    = X_W(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: line storage is deliberately not reset; stale words are masked by
  // the top level, and a reset here would forbid mapping onto RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/line_window_buffer.sv
// Streaming column generator over ROWS-1 stored lines. Define
// LWB_BORDER_REPLICATE_EN to emit top-border rows by replicating row 0.
module line_window_buffer
  import lwb_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int PIX_W = 8,
  parameter int ROWS  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PIX_W-1:0]        in_msg,
  input  logic                    in_val,
  output logic                    in_rdy,
  output logic [ROWS*PIX_W-1:0]   out_msg,
  output logic                    out_val,
  input  logic                    out_rdy,
  output logic [X_W(IMG_W)-1:0]   out_x,
  output logic [Y_W(IMG_H)-1:0]   out_y,
  output logic                    out_sof,
  output logic                    out_eol
);

  localparam int XW = X_W(IMG_W);
  localparam int YW = Y_W(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  // Slot 0 is the incoming pixel, slot ROWS-1 the oldest row.
  typedef logic [ROWS-1:0][PIX_W-1:0] col_t;

  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [PIX_W-1:0] rd [ROWS-1];
  col_t             col_raw, col;
  logic             accept, emit, sof_d, eol_d;

  col_t             out_msg_q;
  logic             out_val_q, out_sof_q, out_eol_q;
  logic [XW-1:0]    out_x_q;
  logic [YW-1:0]    out_y_q;

  assign in_rdy = !out_val_q || out_rdy;
  assign accept = in_val && in_rdy;

  // Each line reads the pixel above at x and takes the one below it on accept.
  for (genvar k = 0; k < ROWS - 1; k++) begin : g_line
    lwb_line_mem #(
      .DEPTH(IMG_W),
      .WIDTH(PIX_W),
      .AW   (XW)
    ) u_mem (
      .clk    (clk),
      .we_i   (accept),
      .addr_i (x_q),
      .wdata_i(col_raw[k]),
      .rdata_o(rd[k])
    );
  end

  always_comb begin
    col_raw[0] = in_msg;
    for (int k = 1; k < ROWS; k++) col_raw[k] = rd[k-1];
  end

`ifdef LWB_BORDER_REPLICATE_EN
  // Slots above the frame's first row copy their lower neighbour, so row 0
  // propagates upward.
  always_comb begin
    col = col_raw;
    for (int k = 1; k < ROWS; k++) begin
      if (YW'(k) > y_q) col[k] = col[k-1];
    end
  end

  assign emit  = accept;
  assign sof_d = (x_q == '0) && (y_q == '0);
`else
  localparam logic [YW-1:0] Y_FIRST = YW'(ROWS - 1);

  assign col   = col_raw;
  assign emit  = accept && (y_q >= Y_FIRST);
  assign sof_d = (x_q == '0) && (y_q == Y_FIRST);
`endif

  assign eol_d = (x_q == X_LAST);

  // NOTE: next-state defaults come first so every path assigns x_d/y_d and
  // no latch is inferred.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (accept) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q       <= '0;
      y_q       <= '0;
      out_val_q <= 1'b0;
      out_msg_q <= '0;
      out_x_q   <= '0;
      out_y_q   <= '0;
      out_sof_q <= 1'b0;
      out_eol_q <= 1'b0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      if (accept) begin
        out_val_q <= emit;
        if (emit) begin
          out_msg_q <= col;
          out_x_q   <= x_q;
          out_y_q   <= y_q;
          out_sof_q <= sof_d;
          out_eol_q <= eol_d;
        end
      end else if (out_rdy) begin
        out_val_q <= 1'b0;
      end
    end
  end

  assign out_msg = out_msg_q;
  assign out_val = out_val_q;
  assign out_x   = out_x_q;
  assign out_y   = out_y_q;
  assign out_sof = out_sof_q;
  assign out_eol = out_eol_q;

endmodule
